// File: rtl/mux_sel_arbiter_pkg.sv
// ============================================================================
// Module      : mux_sel_arbiter_pkg
// Description : Shared state encoding, select polarity and defaults for the
//               A/B mux select arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mux_sel_arbiter_pkg;

  localparam int unsigned W_DEFAULT     = 4;
  localparam int unsigned BURST_DEFAULT = 4;

  localparam logic SEL_A = 1'b1;
  localparam logic SEL_B = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN_A = 2'd1,
    ST_OWN_B = 2'd2
  } arb_state_e;

endpackage : mux_sel_arbiter_pkg

`default_nettype wire

// File: rtl/mux_sel_arbiter_burst_counter.sv
// ============================================================================
// Module      : burst_counter
// Description : Counts accepted beats within one ownership burst; flags the
//               last permitted beat (BURST-1).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module burst_counter #(
  parameter int BURST = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic inc_i,
  output logic term_o
);

  localparam int CW = (BURST > 1) ? $clog2(BURST) : 1;
  localparam logic [CW-1:0] c_TERM = CW'(BURST - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign term_o = (cnt_q == c_TERM);

  // Saturate at the terminal value so the count can never pass BURST-1.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (inc_i && !term_o) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule : burst_counter

`default_nettype wire

// File: rtl/mux_sel_arbiter.sv
// ============================================================================
// Module      : mux_sel_arbiter
// Description : Round-robin, burst-bounded arbiter for two valid/ready
//               producers driving a 2:1 mux select and a one-entry output slot.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_sel_arbiter
  import mux_sel_arbiter_pkg::*;
#(
  parameter int W     = W_DEFAULT,
  parameter int BURST = BURST_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         a_valid,
  input  logic [W-1:0] a_data,
  output logic         a_ready,
  input  logic         b_valid,
  input  logic [W-1:0] b_data,
  output logic         b_ready,
  output logic         sel,
  output logic         y_valid,
  output logic [W-1:0] y_data,
  input  logic         y_ready
);

  arb_state_e   state_q, state_d;
  logic         sel_q, sel_d;
  logic         last_a_q;
  logic         y_valid_q;
  logic [W-1:0] y_data_q;

  logic         w_own_a, w_own_b;
  logic         w_slot_free;
  logic         w_x_valid, w_other_valid;
  logic [W-1:0] w_x_data;
  logic         w_xfer, w_done;
  logic         w_cnt_term, w_cnt_clear;

  assign w_own_a     = (state_q == ST_OWN_A);
  assign w_own_b     = (state_q == ST_OWN_B);
  assign w_slot_free = !y_valid_q || y_ready;

  // Ready is a function of state and y_ready only, never of the source valid.
  assign a_ready = w_own_a && w_slot_free;
  assign b_ready = w_own_b && w_slot_free;

  assign w_x_valid     = w_own_a ? a_valid : b_valid;
  assign w_other_valid = w_own_a ? b_valid : a_valid;
  assign w_x_data      = (sel_q == SEL_A) ? a_data : b_data;
  assign w_xfer        = (a_valid && a_ready) || (b_valid && b_ready);
  assign w_done        = (w_xfer && w_cnt_term) || !w_x_valid;
  assign w_cnt_clear   = (state_q == ST_IDLE) || w_done;

  burst_counter #(
    .BURST (BURST)
  ) u_burst_counter (
    .clk     (clk),
    .rst     (rst),
    .clear_i (w_cnt_clear),
    .inc_i   (w_xfer),
    .term_o  (w_cnt_term)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (a_valid && b_valid) begin
          state_d = last_a_q ? ST_OWN_B : ST_OWN_A;
        end else if (a_valid) begin
          state_d = ST_OWN_A;
        end else if (b_valid) begin
          state_d = ST_OWN_B;
        end
      end
      ST_OWN_A: begin
        if (w_done) begin
          if (b_valid) begin
            state_d = ST_OWN_B;
          end else if (!a_valid) begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_OWN_B: begin
        if (w_done) begin
          if (a_valid) begin
            state_d = ST_OWN_A;
          end else if (!b_valid) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Select tracks the owner and simply holds through IDLE.
    sel_d = sel_q;
    if (state_d == ST_OWN_A) begin
      sel_d = SEL_A;
    end else if (state_d == ST_OWN_B) begin
      sel_d = SEL_B;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      sel_q     <= SEL_B;
      last_a_q  <= 1'b0;
      y_valid_q <= 1'b0;
      y_data_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      if (w_xfer) begin
        y_data_q  <= w_x_data;
        y_valid_q <= 1'b1;
        last_a_q  <= w_own_a;
      end else if (y_valid_q && y_ready) begin
        y_valid_q <= 1'b0;
      end
    end
  end

  assign sel     = sel_q;
  assign y_valid = y_valid_q;
  assign y_data  = y_data_q;

endmodule : mux_sel_arbiter

`default_nettype wire

// File: tb/tb_mux_sel_arbiter.sv
// ============================================================================
// Module      : tb_mux_sel_arbiter
// Description : Randomized self-checking bench for mux_sel_arbiter with an
//               ownership/burst reference model and an in-order word scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mux_sel_arbiter;

  localparam int W     = 4;
  localparam int BURST = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         a_valid, b_valid, y_ready;
  logic [W-1:0] a_data, b_data;
  logic         a_ready, b_ready, sel, y_valid;
  logic [W-1:0] y_data;

  always #5 clk = ~clk;

  mux_sel_arbiter #(.W(W), .BURST(BURST)) dut (
    .clk     (clk),
    .rst     (rst),
    .a_valid (a_valid),
    .a_data  (a_data),
    .a_ready (a_ready),
    .b_valid (b_valid),
    .b_data  (b_data),
    .b_ready (b_ready),
    .sel     (sel),
    .y_valid (y_valid),
    .y_data  (y_data),
    .y_ready (y_ready)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: owner 0=nobody, 1=A, 2=B; beats = words taken in this burst.
  int           m_owner;
  bit           m_sel, m_last_a, m_yv;
  int           m_beats;
  logic [W-1:0] m_yd;
  bit           m_a_acc, m_b_acc;
  bit           obs_yv;
  logic [W-1:0] obs_yd;
  logic [W-1:0] exp_q[$];

  task automatic model_reset();
    m_owner = 0; m_sel = 0; m_last_a = 0; m_beats = 0; m_yv = 0; m_yd = '0;
    exp_q.delete();
  endtask

  task automatic model_check();
    bit free;
    free = !m_yv || y_ready;
    chk("a_ready", {31'd0, a_ready}, {31'd0, (m_owner == 1) && free});
    chk("b_ready", {31'd0, b_ready}, {31'd0, (m_owner == 2) && free});
    chk("sel",     {31'd0, sel},     {31'd0, m_sel});
    chk("y_valid", {31'd0, y_valid}, {31'd0, m_yv});
    chk("y_data",  {28'd0, y_data},  {28'd0, m_yd});
    obs_yv = y_valid;
    obs_yd = y_data;
  endtask

  task automatic model_step();
    bit free, xv, ov, took, finished;
    logic [W-1:0] xd;
    m_a_acc = 0; m_b_acc = 0;
    if (rst) begin
      model_reset();
      return;
    end
    if (obs_yv && y_ready) begin
      chk("sb_nonempty", {31'd0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) chk("sb_word", {28'd0, obs_yd}, {28'd0, exp_q.pop_front()});
    end
    free = !m_yv || y_ready;
    if (m_owner == 0) begin
      if (m_yv && y_ready) m_yv = 0;
      if (a_valid && b_valid) m_owner = m_last_a ? 2 : 1;
      else if (a_valid)       m_owner = 1;
      else if (b_valid)       m_owner = 2;
      if (m_owner != 0) m_sel = (m_owner == 1);
      m_beats = 0;
    end else begin
      xv   = (m_owner == 1) ? a_valid : b_valid;
      ov   = (m_owner == 1) ? b_valid : a_valid;
      xd   = (m_owner == 1) ? a_data  : b_data;
      took = xv && free;
      finished = (took && (m_beats + 1 == BURST)) || !xv;
      if (took) begin
        m_yd = xd; m_yv = 1; m_last_a = (m_owner == 1);
        exp_q.push_back(xd);
        if (m_owner == 1) m_a_acc = 1; else m_b_acc = 1;
      end else if (m_yv && y_ready) begin
        m_yv = 0;
      end
      if (!finished) begin
        m_beats += int'(took);
      end else begin
        m_beats = 0;
        if (ov) begin
          m_owner = 3 - m_owner;
          m_sel   = (m_owner == 1);
        end else if (!xv) begin
          m_owner = 0;
        end
      end
    end
  endtask

  // One clock: drive, check before the edge, advance model at the edge.
  task automatic cycle(input bit r, input bit av, input bit bv, input bit yr);
    rst = r; a_valid = av; b_valid = bv; y_ready = yr;
    #1;
    model_check();
    @(posedge clk);
    model_step();
    #1;
    if (m_a_acc) a_data = W'($urandom);
    if (m_b_acc) b_data = W'($urandom);
  endtask

  initial begin
    rst = 1'b1; a_valid = 1'b1; b_valid = 1'b1; y_ready = 1'b1;
    a_data = W'($urandom); b_data = W'($urandom);
    model_reset();
    repeat (2) @(posedge clk);
    #1;

    repeat (2) cycle(1, 1, 1, 1);
    repeat (2) cycle(0, 1, 1, 1);
    repeat (3) cycle(1, 0, 0, 1);

    repeat (6) cycle(0, 1, 0, 1);
    repeat (2) cycle(0, 0, 0, 1);
    repeat (30) cycle(0, 1, 1, 1);

    repeat (3) cycle(0, 1, 1, 0);
    repeat (8) cycle(0, 1, 1, 1);

    repeat (3) cycle(0, 0, 0, 1);
    repeat (3) cycle(0, 1, 1, 1);
    repeat (6) cycle(0, 0, 1, 1);

    repeat (3) cycle(0, 1, 1, 1);
    cycle(1, 1, 1, 0);
    repeat (8) cycle(0, 0, 1, 1);

    for (int i = 0; i < 3000; i++) begin
      int mode;
      mode = (i / 250) % 4;
      case (mode)
        0: cycle($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
        1: cycle(1'b0, 1'b1, 1'b1, $urandom_range(0, 1) == 1);
        2: cycle($urandom_range(0, 199) == 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 1) == 1, 1'b1);
        default: cycle(1'b0, $urandom_range(0, 4) != 0,
                       $urandom_range(0, 4) == 0, $urandom_range(0, 4) != 0);
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_mux_sel_arbiter

`default_nettype wire
